div_flex_seq: RTL and testbench
===============================

DIV_FLEX_SEQ -- requirements
Module: div_flex_seq

Interface
REQ-001 SHALL have parameter A_W, default 16: dividend and quotient width.
REQ-002 SHALL have parameter B_W, default 8: divisor width; remainder is B_W+1 bits.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port a  input  A_W  dividend.
REQ-008 SHALL have port a_s  input  1  1 = a is two's-complement signed, 0 = unsigned.
REQ-009 SHALL have port b  input  B_W  divisor.
REQ-010 SHALL have port b_s  input  1  1 = b is signed, 0 = unsigned.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port quo  output  A_W  quotient.
REQ-014 SHALL have port rem  output  B_W+1  remainder, two's complement.
REQ-015 SHALL have port div_zero  output  1  divisor was zero.

Function
REQ-016 SHALL implement states IDLE, CALC, SIGN, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE.
REQ-018 SHALL drive out_valid = 1 only in DONE.
REQ-019 SHALL accept on a clock edge with in_valid && in_ready, capture a, a_s, b, b_s and move IDLE->CALC.
REQ-020 SHALL extend each operand by one MSB = (MSB & sign flag) and take its magnitude.
REQ-021 SHALL do one restoring-division step per CALC cycle, one quotient bit per step, MSB first, for exactly A_W cycles.
REQ-022 SHALL move CALC->SIGN after the A_W-th step.
REQ-023 SHALL, in SIGN (one cycle), negate the quotient when exactly one extended operand is negative and negate the remainder when the extended dividend is negative, then move to DONE.
REQ-024 SHALL implement truncating division: quotient rounds toward zero; rem carries the dividend's sign or is 0; |rem| < |b|.
REQ-025 SHALL output quo as the A_W LSBs of the exact quotient; overflow (e.g. signed -2^(A_W-1) / -1, or unsigned a / signed -1) wraps silently.
REQ-026 SHALL give fixed latency: out_valid rises on the (A_W+2)-th rising edge after the accept edge, for every operand value including b = 0.
REQ-027 SHALL, when b = 0, set div_zero = 1, quo = all ones and rem = a[B_W:0], independent of a_s and b_s; otherwise div_zero = 0.
REQ-028 SHALL hold quo, rem and div_zero stable in DONE while out_ready = 0, for any number of cycles.
REQ-029 SHALL move DONE->IDLE on an edge with out_ready = 1; in_ready rises in the following cycle; no new accept happens in that DONE cycle.
REQ-030 SHALL ignore in_valid and operand changes outside IDLE.
REQ-031 SHALL keep quo, rem and div_zero at their last values in IDLE, CALC and SIGN; they are meaningful only while out_valid = 1.

Reset
REQ-032 SHALL, while reset = 1, immediately force state IDLE, out_valid = 0, in_ready = 1, quo = 0, rem = 0, div_zero = 0 and clear all internal registers.
REQ-033 SHALL, when reset is asserted in CALC, SIGN or DONE, abort and discard the operation with no result ever presented.
REQ-034 SHALL allow an accept on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL cover unsigned: A_W=16, B_W=8, a=1000, b=7, a_s=b_s=0 -> quo=142, rem=6, div_zero=0, out_valid on edge accept+18.
REQ-036 SHALL cover signed: a=0xFF9C (-100), b=0x07, a_s=b_s=1 -> quo=0xFFF2 (-14), rem=0x1FE (-2). Then a=100, b=0xF9 (-7), both signed -> quo=0xFFF2, rem=0x002.
REQ-037 SHALL cover mixed signedness: a=100, a_s=1, b=0xF9, b_s=0 (249) -> quo=0, rem=0x064. Also a=0xFF9C signed, b=0xF9 unsigned -> quo=0, rem=0x19C (-100).
REQ-038 SHALL cover zero and overflow: a=0x1234, b=0 -> div_zero=1, quo=0xFFFF, rem=0x034, same latency. a=0x8000, b=0xFF, both signed -> quo=0x8000, rem=0.
REQ-039 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-040 SHALL cover reset mid-CALC: reset at step 5 -> out_valid stays 0, in_ready=1 after release, a new operation completes correctly.

Source files
------------

// File: rtl/div_flex_seq.sv
// div_flex_seq: fixed-latency restoring divider with per-operand signedness and a valid/ready handshake
module div_flex_seq #(
  parameter int A_W = 16,
  parameter int B_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic           a_s,
  input  logic [B_W-1:0] b,
  input  logic           b_s,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W-1:0] quo,
  output logic [B_W:0]   rem,
  output logic           div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  localparam int C_W = $clog2(A_W + 2);
  state_t         r_state;
  logic [C_W-1:0] r_cnt;
  logic [A_W-1:0] r_a, r_q;
  logic [B_W-1:0] r_b, r_bm;
  logic [B_W:0]   r_r;
  logic           r_as, r_bs;
  logic           w_an, w_bn, w_bz;
  logic [A_W-1:0] w_am;
  logic [B_W-1:0] w_bm;
  logic [B_W:0]   w_sh;
  logic [B_W+1:0] w_df;
  assign w_an = r_as & r_a[A_W-1];
  assign w_bn = r_bs & r_b[B_W-1];
  assign w_bz = r_b == '0;
  assign w_am = w_an ? -r_a : r_a;
  assign w_bm = w_bn ? -r_b : r_b;
  // the partial remainder stays below |b|, so its top bit is free for the shift
  assign w_sh = {r_r[B_W-1:0], r_q[A_W-1]};
  assign w_df = {1'b0, w_sh} - {2'b0, r_bm};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_as      <= 1'b0;
      r_bs      <= 1'b0;
      r_q       <= '0;
      r_bm      <= '0;
      r_r       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      div_zero  <= 1'b0;
    end else
      case (r_state)
        IDLE: if (in_valid && in_ready) begin
          r_a      <= a;
          r_as     <= a_s;
          r_b      <= b;
          r_bs     <= b_s;
          r_cnt    <= '0;
          in_ready <= 1'b0;
          r_state  <= CALC;
        end
        CALC: begin
          r_cnt <= r_cnt + C_W'(1);
          // first CALC cycle loads magnitudes; the next A_W cycles each retire one quotient bit
          if (r_cnt == '0) begin
            r_q  <= w_am;
            r_bm <= w_bm;
            r_r  <= '0;
          end else begin
            r_q <= {r_q[A_W-2:0], ~w_df[B_W+1]};
            r_r <= w_df[B_W+1] ? w_sh : w_df[B_W:0];
            if (r_cnt == C_W'(A_W)) r_state <= SIGN;
          end
        end
        SIGN: begin
          div_zero  <= w_bz;
          quo       <= w_bz ? '1 : (w_an ^ w_bn) ? -r_q : r_q;
          rem       <= w_bz ? r_a[B_W:0] : w_an ? -r_r : r_r;
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_div_flex_seq.sv
// tb_div_flex_seq: directed and randomized checks of div_flex_seq against an integer-arithmetic model
module tb_div_flex_seq;
  localparam int A_W = 16;
  localparam int B_W = 8;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, a_s = 1'b0, b_s = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, div_zero;
  logic [A_W-1:0] a = '0, quo;
  logic [B_W-1:0] b = '0;
  logic [B_W:0]   rem;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  div_flex_seq #(.A_W(A_W), .B_W(B_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .a_s(a_s), .b(b), .b_s(b_s), .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .rem(rem), .div_zero(div_zero)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [15:0] ta, input logic tas, input logic [7:0] tb, input logic tbs,
                                output logic [15:0] eq, output logic [8:0] er, output logic ez);
    longint av, bv, q, r;
    av = tas ? longint'($signed(ta)) : longint'(ta);
    bv = tbs ? longint'($signed(tb)) : longint'(tb);
    if (bv == 0) begin
      eq = '1;
      er = ta[8:0];
      ez = 1'b1;
    end else begin
      q  = av / bv;
      r  = av % bv;
      eq = q[15:0];
      er = r[8:0];
      ez = 1'b0;
    end
  endfunction
  // called just after a falling edge with the block idle
  task automatic do_op(input string tag, input logic [15:0] ta, input logic tas, input logic [7:0] tb, input logic tbs,
                       input logic [15:0] eq, input logic [8:0] er, input logic ez, input int hold);
    int n;
    chk({tag, "_rdy"}, {31'b0, in_ready}, 1);
    a = ta; a_s = tas; b = tb; b_s = tbs; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 8'($urandom); a_s = ~tas; b_s = ~tbs;
    chk({tag, "_busy"}, {30'b0, out_valid, in_ready}, 0);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, A_W + 2);
    chk({tag, "_quo"}, {16'b0, quo}, {16'b0, eq});
    chk({tag, "_rem"}, {23'b0, rem}, {23'b0, er});
    chk({tag, "_dz"}, {31'b0, div_zero}, {31'b0, ez});
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; a = 16'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk({tag, "_hold"}, {4'b0, out_valid, in_ready, div_zero, rem, quo}, {4'b0, 1'b1, 1'b0, ez, er, eq});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel"}, {30'b0, out_valid, in_ready}, 1);
  endtask
  initial begin
    logic [15:0] eq, ra;
    logic [8:0]  er;
    logic [7:0]  rb;
    logic        ez, ras, rbs, seen;
    #2 reset = 1'b1;
    #1 chk("reset", {4'b0, out_valid, in_ready, div_zero, rem, quo}, {4'b0, 1'b0, 1'b1, 1'b0, 9'h0, 16'h0});
    @(negedge clk);
    reset = 1'b0;
    do_op("unsigned", 16'd1000, 1'b0, 8'd7, 1'b0, 16'd142, 9'd6, 1'b0, 0);
    do_op("sgn_neg_a", 16'hFF9C, 1'b1, 8'h07, 1'b1, 16'hFFF2, 9'h1FE, 1'b0, 1);
    do_op("sgn_neg_b", 16'd100, 1'b1, 8'hF9, 1'b1, 16'hFFF2, 9'h002, 1'b0, 0);
    do_op("mix_pos", 16'd100, 1'b1, 8'hF9, 1'b0, 16'h0000, 9'h064, 1'b0, 2);
    do_op("mix_neg", 16'hFF9C, 1'b1, 8'hF9, 1'b0, 16'h0000, 9'h19C, 1'b0, 0);
    do_op("zero_u", 16'h1234, 1'b0, 8'h00, 1'b0, 16'hFFFF, 9'h034, 1'b1, 0);
    do_op("zero_s", 16'h8F00, 1'b1, 8'h00, 1'b1, 16'hFFFF, 9'h100, 1'b1, 1);
    do_op("ovf_s", 16'h8000, 1'b1, 8'hFF, 1'b1, 16'h8000, 9'h000, 1'b0, 0);
    do_op("ovf_u", 16'hFFFF, 1'b0, 8'hFF, 1'b1, 16'h0001, 9'h000, 1'b0, 0);
    do_op("backpr", 16'hFFFF, 1'b0, 8'hFF, 1'b0, 16'd257, 9'h000, 1'b0, 5);
    a = 16'd5000; a_s = 1'b0; b = 8'd3; b_s = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_mid", {4'b0, out_valid, in_ready, div_zero, rem, quo}, {4'b0, 1'b0, 1'b1, 1'b0, 9'h0, 16'h0});
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    chk("rst_abort", {31'b0, seen}, 0);
    do_op("post_rst", 16'hFF9C, 1'b1, 8'd9, 1'b0, 16'hFFF5, 9'h1FF, 1'b0, 0);
    for (int i = 0; i < 25; i++) begin
      ra  = 16'($urandom);
      rb  = (i % 7 == 0) ? 8'h00 : 8'($urandom);
      ras = 1'($urandom);
      rbs = 1'($urandom);
      model(ra, ras, rb, rbs, eq, er, ez);
      do_op("rand", ra, ras, rb, rbs, eq, er, ez, i % 3);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
